// File: rtl/toy_pkg.sv
// Shared types and widths for the Toy core trace path.
// Trace entries are packed {pc, a, t}, pc in the top bits.
package toy_pkg;

  localparam int TOY_PC_W    = 12;
  localparam int TOY_WORD_W  = 16;
  localparam int TOY_TRACE_W = TOY_PC_W + 2 * TOY_WORD_W;

  typedef struct packed {
    logic [TOY_PC_W-1:0]   pc;
    logic [TOY_WORD_W-1:0] a;
    logic [TOY_WORD_W-1:0] t;
  } toy_trace_t;

  typedef enum logic {
    SEQ_HOLD,
    SEQ_RUN
  } toy_seq_e;

endpackage

// File: rtl/toy_trace_fifo.sv
// Generic first-word-fall-through FIFO.
// Full and empty are derived from the occupancy count.
module toy_trace_fifo #(
  parameter int W     = 44,
  parameter int DEPTH = 16,
  localparam int AW   = $clog2(DEPTH),
  localparam int LW   = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic [W-1:0]  wdata_i,
  output logic [W-1:0]  rdata_o,
  output logic [LW-1:0] fill_level_o,
  output logic          full_o,
  output logic          empty_o
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] cnt_q, cnt_d;
  logic          do_push;
  logic          do_pop;

  assign empty_o      = (cnt_q == '0);
  assign full_o       = (cnt_q == LW'(DEPTH));
  assign fill_level_o = cnt_q;
  assign rdata_o      = empty_o ? '0 : mem_q[rd_ptr_q];

  // A full FIFO still takes a push when the head leaves this cycle.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    unique case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + LW'(1);
      2'b01:   cnt_d = cnt_q - LW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/toy_trace_buffer.sv
// Owns the Toy core reset and records a trace entry on every pc change.
// Entries queue in a FWFT FIFO drained by the host over valid/ready.
module toy_trace_buffer
  import toy_pkg::*;
#(
  parameter int DEPTH        = 16,
  parameter int RESET_CYCLES = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  output logic                         core_reset,
  input  logic [TOY_PC_W-1:0]          pc_in,
  input  logic [TOY_WORD_W-1:0]        reg_a_in,
  input  logic [TOY_WORD_W-1:0]        reg_t_in,
  input  logic                         trace_en,
  output logic                         rd_valid,
  input  logic                         rd_ready,
  output logic [TOY_TRACE_W-1:0]       rd_data,
  output logic [$clog2(DEPTH+1)-1:0]   fill_level,
  output logic                         overflow,
  output logic [15:0]                  drop_count
);

  localparam int CW = $clog2(RESET_CYCLES + 1);

  toy_seq_e              state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [TOY_PC_W-1:0]   prev_pc_q, prev_pc_d;
  logic                  first_q, first_d;
  logic                  ovf_q, ovf_d;
  logic [15:0]           drop_q, drop_d;

  toy_trace_t            entry;
  logic                  run;
  logic                  push;
  logic                  pop;
  logic                  full;
  logic                  empty;

  assign run   = (state_q == SEQ_RUN);
  assign push  = run && trace_en &&
                 (first_q || (pc_in != prev_pc_q));
  assign pop   = rd_valid && rd_ready;
  assign entry = '{pc: pc_in, a: reg_a_in, t: reg_t_in};

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    prev_pc_d = prev_pc_q;
    first_d   = first_q;
    ovf_d     = ovf_q;
    drop_d    = drop_q;
    unique case (state_q)
      SEQ_HOLD: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_d == CW'(RESET_CYCLES)) state_d = SEQ_RUN;
      end
      SEQ_RUN: begin
        prev_pc_d = pc_in;
      end
      default: state_d = SEQ_HOLD;
    endcase
    // Disabled cycles re-arm so the next enabled cycle always captures.
    if (run && !trace_en) first_d = 1'b1;
    else if (push)        first_d = 1'b0;
    if (push && full && !pop) begin
      ovf_d = 1'b1;
      if (drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= SEQ_HOLD;
      cnt_q     <= '0;
      prev_pc_q <= '0;
      first_q   <= 1'b1;
      ovf_q     <= 1'b0;
      drop_q    <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      prev_pc_q <= prev_pc_d;
      first_q   <= first_d;
      ovf_q     <= ovf_d;
      drop_q    <= drop_d;
    end
  end

  toy_trace_fifo #(
    .W     (TOY_TRACE_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk          (clk),
    .reset        (reset),
    .push_i       (push),
    .pop_i        (rd_ready),
    .wdata_i      (entry),
    .rdata_o      (rd_data),
    .fill_level_o (fill_level),
    .full_o       (full),
    .empty_o      (empty)
  );

  assign core_reset = reset || !run;
  assign rd_valid   = !empty;
  assign overflow   = ovf_q;
  assign drop_count = drop_q;

endmodule

// File: doc/toy_trace_buffer.md
# toy_trace_buffer

Synthesizable counterpart of the Toy bench: it owns the Toy core's reset and captures the core's architectural outputs. It sequences `core_reset` after system reset and records a trace entry each time the core's program counter changes. Entries go into a FIFO, which a host drains over a valid/ready port. It sits between the board-level clock/reset and the Toy core, alongside it on the same clock.

## Interface
Parameters:
- `DEPTH`, 16: FIFO entries; power of two, ≥2.
- `RESET_CYCLES`, 2: clocks `core_reset` stays high after `reset` deasserts; ≥1.

Ports:
- `clk`  in  1  system clock; all logic on its rising edge.
- `reset`  in  1  **one clock; reset is asynchronous and active-high.**
- `core_reset`  out  1  reset to the Toy core.
- `pc_in`  in  12  core program counter.
- `reg_a_in`  in  16  core register A.
- `reg_t_in`  in  16  core register T.
- `trace_en`  in  1  capture enable.
- `rd_valid`  out  1  head entry available.
- `rd_ready`  in  1  host accepts head entry.
- `rd_data`  out  44  head entry: {pc[43:32], A[31:16], T[15:0]}.
- `fill_level`  out  $clog2(DEPTH+1)  entries held.
- `overflow`  out  1  sticky; an entry was dropped.
- `drop_count`  out  16  saturating count of dropped entries.

## Operation
- Reset values:
  - `core_reset`=1.
  - `rd_valid`=0.
  - `rd_data`=0.
  - `fill_level`=0.
  - `overflow`=0.
  - `drop_count`=0.
  - Internal `prev_pc`=0.
  - `first`=1.
- **Reset sequencer states:**
  - HOLD: `core_reset`=1 and the counter counts up to RESET_CYCLES. Move to RUN when the count reaches RESET_CYCLES.
  - RUN: `core_reset`=0.
  - Only `reset` returns the block to HOLD.
- **Capture window:** state RUN and `trace_en`=1.
- **Capture condition** (evaluated each cycle in the window):
  - Capture when `first`=1 or `pc_in`≠`prev_pc`.
  - On capture, push {`pc_in`,`reg_a_in`,`reg_t_in`} sampled that cycle and clear `first`.
- **prev_pc:** loads `pc_in` every cycle in RUN, regardless of `trace_en`.
- **trace_en falling:** sets `first`=1, so the next enabled cycle always captures.
- **Pop:** `rd_valid`&&`rd_ready`. `rd_data` presents the head entry (first-word-fall-through) and is stable while `rd_valid`=1 and no pop occurs.
- **Full FIFO:**
  - A push without a simultaneous pop is dropped: `overflow` sets and `drop_count` increments, saturating at 0xFFFF.
  - A push with a simultaneous pop is accepted; `fill_level` is unchanged.
- **Empty FIFO:** a pop is impossible (`rd_valid`=0), so `rd_ready` is ignored.
- **Clearing:** `overflow` and `drop_count` clear only on `reset`.
- **Pointer wrap:** pointers are $clog2(DEPTH) bits and wrap modulo DEPTH; full/empty come from `fill_level`.

## Timing
- **`core_reset`:** `reset` asserted forces it to 1 asynchronously. It deasserts on the RESET_CYCLES-th rising edge after `reset` falls.
- **Capture latency:** a capture at edge N appears as `rd_valid`=1 with `rd_data` valid after edge N, and `fill_level` updates at the same edge.
- **Pop latency:** a pop at edge N exposes the next entry, or `rd_valid`=0, after edge N.
- **Push and pop on the same edge, FIFO non-empty:** both take effect and `fill_level` is unchanged.
- **Push and pop on the same edge, FIFO empty:** there is no pop (`rd_valid`=0), so the push alone takes effect.
- **`reset` mid-operation:**
  - The FIFO empties and all counters clear asynchronously.
  - `core_reset` reasserts.
  - Entries in flight are lost.
- **Throughput:** one capture and one pop per cycle, sustained.

## Structure
- **Shared package `toy_pkg`:**
  - `TOY_PC_W`=12 and `TOY_WORD_W`=16.
  - Typedef `toy_trace_t` (packed {pc, a, t}).
  - `TOY_TRACE_W`=44.
- **Sub-module `toy_trace_fifo`:**
  - Generic FWFT FIFO parameterized by width and DEPTH.
  - Ports: push/pop/data/fill_level/full/empty.
- **Top level:** sequencer, capture logic and drop counters.

## Test plan
- **Reset sequencing:** `reset`=1 for 3 cycles, then 0, RESET_CYCLES=2 -> `core_reset` falls exactly 2 edges later. All other outputs are 0 throughout reset.
- **Change detection:** `trace_en`=1, pc sequence 0x000,0x000,0x001,0x001,0x005 -> exactly 3 entries in order: {0x000,..},{0x001,..},{0x005,..}, and `fill_level`=3.
- **Overflow:** `rd_ready`=0, pc changes every cycle for DEPTH+3 cycles -> `fill_level`=DEPTH, `overflow`=1, `drop_count`=3. Draining then yields the first DEPTH pcs in order.
- **Full push+pop:** FIFO full and `rd_ready`=1 while a new pc arrives -> entry accepted, `fill_level` stays DEPTH, `drop_count` unchanged.
- **Re-arm:** `trace_en` toggles 1->0->1 with pc held at 0x0AB -> a second 0x0AB entry is captured on re-enable.
- **Reset mid-operation:** assert `reset` with 5 entries held -> `rd_valid`=0, `fill_level`=0, `core_reset`=1 immediately, without waiting for a clock edge.
